// File: rtl/bfm_ahbmaster_cmd_if.sv
// Command port, AHB-Lite master bus and response port of the BFM master.
// The master modport is the bus-initiator side; slave is the bench side.
interface bfm_ahbmaster_cmd_if #(
  parameter int AWIDTH = 32
);
  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_WRITE;
  logic [AWIDTH-1:0] CMD_ADDR;
  logic [1:0]        CMD_SIZE;
  logic [3:0]        CMD_LEN;
  logic [31:0]       CMD_WDATA;

  logic [AWIDTH-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic              HMASTLOCK;
  logic [3:0]        HPROT;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic              HRESP;

  logic              RSP_VALID;
  logic [31:0]       RSP_RDATA;
  logic              RSP_ERROR;
  logic              RSP_LAST;

  modport master (
    input  CMD_VALID,
    output CMD_READY,
    input  CMD_WRITE,
    input  CMD_ADDR,
    input  CMD_SIZE,
    input  CMD_LEN,
    input  CMD_WDATA,
    output HADDR,
    output HTRANS,
    output HWRITE,
    output HSIZE,
    output HBURST,
    output HMASTLOCK,
    output HPROT,
    output HWDATA,
    input  HRDATA,
    input  HREADY,
    input  HRESP,
    output RSP_VALID,
    output RSP_RDATA,
    output RSP_ERROR,
    output RSP_LAST
  );

  modport slave (
    output CMD_VALID,
    input  CMD_READY,
    output CMD_WRITE,
    output CMD_ADDR,
    output CMD_SIZE,
    output CMD_LEN,
    output CMD_WDATA,
    input  HADDR,
    input  HTRANS,
    input  HWRITE,
    input  HSIZE,
    input  HBURST,
    input  HMASTLOCK,
    input  HPROT,
    input  HWDATA,
    output HRDATA,
    output HREADY,
    output HRESP,
    input  RSP_VALID,
    input  RSP_RDATA,
    input  RSP_ERROR,
    input  RSP_LAST
  );
endinterface

// File: rtl/bfm_ahbmaster_cmd.sv
// Command-driven AHB-Lite master: single/INCR bursts, wait states,
// two-cycle ERROR, one registered response pulse per completed beat.
module bfm_ahbmaster_cmd #(
  parameter int         AWIDTH    = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input logic                 HCLK,
  input logic                 HRESET,
  bfm_ahbmaster_cmd_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_PIPE = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [2:0]        state;
  logic [2:0]        state_n;
  logic              rdy_q;
  logic [AWIDTH-1:0] haddr_q;
  logic [AWIDTH-1:0] addr_inc;
  logic              hwrite_q;
  logic [1:0]        size_q;
  logic [2:0]        hburst_q;
  logic [3:0]        len_q;
  logic [3:0]        a_idx;
  logic [3:0]        d_idx;
  logic [31:0]       seed_q;
  logic              rsp_v_q;
  logic              rsp_e_q;
  logic              rsp_l_q;
  logic [31:0]       rsp_d_q;
  logic [1:0]        htrans;
  logic [1:0]        cmd_sz;
  logic              accept;
  logic              data_ph;
  logic              beat_done;
  logic              last_addr;

  assign cmd_sz    = (bus.CMD_SIZE == 2'd3) ? 2'd2 : bus.CMD_SIZE;
  assign accept    = (state == S_IDLE) && rdy_q && bus.CMD_VALID;
  assign data_ph   = (state == S_PIPE) || (state == S_DATA) ||
                     (state == S_ERR);
  assign beat_done = data_ph && bus.HREADY;
  assign last_addr = (a_idx == len_q);
  assign addr_inc  = AWIDTH'(1) << size_q;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) state_n = S_ADDR;
      end
      S_ADDR: begin
        if (bus.HREADY)
          state_n = (len_q == 4'd0) ? S_DATA : S_PIPE;
      end
      S_PIPE: begin
        if (bus.HRESP && !bus.HREADY)
          state_n = S_ERR;
        else if (bus.HRESP)
          state_n = S_IDLE;
        else if (bus.HREADY)
          state_n = last_addr ? S_DATA : S_PIPE;
      end
      S_DATA: begin
        if (bus.HRESP && !bus.HREADY)
          state_n = S_ERR;
        else if (bus.HREADY)
          state_n = S_IDLE;
      end
      S_ERR: begin
        if (bus.HREADY) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A new address at a 1 KB boundary must restart the burst with NONSEQ.
  always_comb begin
    htrans = TR_IDLE;
    if (state == S_ADDR)
      htrans = TR_NONSEQ;
    else if (state == S_PIPE)
      htrans = (haddr_q[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= S_IDLE;
      rdy_q    <= 1'b0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      size_q   <= 2'd0;
      hburst_q <= 3'd0;
      len_q    <= 4'd0;
      a_idx    <= 4'd0;
      d_idx    <= 4'd0;
      seed_q   <= 32'd0;
      rsp_v_q  <= 1'b0;
      rsp_e_q  <= 1'b0;
      rsp_l_q  <= 1'b0;
      rsp_d_q  <= 32'd0;
    end else begin
      state   <= state_n;
      rdy_q   <= (state_n == S_IDLE);
      rsp_v_q <= 1'b0;
      rsp_e_q <= 1'b0;
      rsp_l_q <= 1'b0;
      rsp_d_q <= 32'd0;

      if (accept) begin
        haddr_q  <= bus.CMD_ADDR;
        hwrite_q <= bus.CMD_WRITE;
        size_q   <= cmd_sz;
        hburst_q <= (bus.CMD_LEN == 4'd0) ? 3'b000 : 3'b001;
        len_q    <= bus.CMD_LEN;
        seed_q   <= bus.CMD_WDATA;
        a_idx    <= 4'd0;
        d_idx    <= 4'd0;
      end

      if (state == S_ADDR && bus.HREADY && len_q != 4'd0) begin
        haddr_q <= haddr_q + addr_inc;
        a_idx   <= 4'd1;
      end

      if (state == S_PIPE && bus.HREADY && !bus.HRESP) begin
        d_idx <= d_idx + 4'd1;
        if (!last_addr) begin
          a_idx   <= a_idx + 4'd1;
          haddr_q <= haddr_q + addr_inc;
        end
      end

      if (beat_done) begin
        rsp_v_q <= 1'b1;
        rsp_d_q <= hwrite_q ? 32'd0 : bus.HRDATA;
        rsp_e_q <= bus.HRESP || (state == S_ERR);
        rsp_l_q <= (state != S_PIPE) || bus.HRESP;
      end
    end
  end

  assign bus.CMD_READY = rdy_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HTRANS    = htrans;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HSIZE     = {1'b0, size_q};
  assign bus.HBURST    = hburst_q;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HWDATA    = (data_ph && hwrite_q) ?
                         (seed_q + 32'(d_idx)) : 32'd0;
  assign bus.RSP_VALID = rsp_v_q;
  assign bus.RSP_RDATA = rsp_d_q;
  assign bus.RSP_ERROR = rsp_e_q;
  assign bus.RSP_LAST  = rsp_l_q;

endmodule
